// File: rtl/decimator_output_fifo_if.sv
// rtl/decimator_output_fifo_if.sv - sample strobe in, valid/ready stream out, level and overflow status
interface decimator_output_fifo_if #(
    parameter int DataWidth = 18,
    parameter int AddrWidth = 4
);
    logic [DataWidth-1:0] Data_i;
    logic                 DataNd_i;
    logic [DataWidth-1:0] Data_o;
    logic                 DataValid_o;
    logic                 DataReady_i;
    logic [AddrWidth:0]   Level_o;
    logic                 Overflow_o;
    logic                 OverflowClr_i;

    modport master (
        output Data_i, DataNd_i, DataReady_i, OverflowClr_i,
        input  Data_o, DataValid_o, Level_o, Overflow_o
    );

    modport slave (
        input  Data_i, DataNd_i, DataReady_i, OverflowClr_i,
        output Data_o, DataValid_o, Level_o, Overflow_o
    );
endinterface

// File: rtl/decimator_output_fifo.sv
// rtl/decimator_output_fifo.sv - gain/saturate stage feeding a drop-on-full FIFO toward the consumer
module decimator_output_fifo #(
    parameter int DataWidth = 18,
    parameter int Depth     = 16,
    parameter int AddrWidth = 4,
    parameter int GainShift = 0
) (
    input  logic                    Clk_i,
    input  logic                    Rst_i,
    decimator_output_fifo_if.slave  bus
);
    localparam int WideWidth = DataWidth + 3;
    localparam logic [AddrWidth:0] LevelFull = (AddrWidth+1)'(Depth);

    logic [WideWidth-1:0]   w_ext;
    logic [WideWidth-1:0]   w_wide;
    logic [3:0]             w_top;
    logic [DataWidth-1:0]   w_sat;

    logic [DataWidth-1:0]   r_stage_data;
    logic                   r_stage_valid;
    logic [DataWidth-1:0]   r_mem [Depth];
    logic [AddrWidth-1:0]   r_wr_ptr;
    logic [AddrWidth-1:0]   r_rd_ptr;
    logic [AddrWidth:0]     r_level;
    logic                   r_overflow;

    logic                   w_full;
    logic                   w_valid;
    logic                   w_rd;
    logic                   w_wr;
    logic                   w_drop;

    // Three guard bits cover the largest shift; the value fits when the guard bits and sign agree.
    assign w_ext  = {{3{bus.Data_i[DataWidth-1]}}, bus.Data_i};
    assign w_wide = w_ext << GainShift;
    assign w_top  = w_wide[WideWidth-1:DataWidth-1];

    always_comb begin
        w_sat = w_wide[DataWidth-1:0];
        if (w_top != 4'b0000 && w_top != 4'b1111) begin
            if (w_wide[WideWidth-1]) begin
                w_sat = {1'b1, {(DataWidth-1){1'b0}}};
            end else begin
                w_sat = {1'b0, {(DataWidth-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            r_stage_valid <= 1'b0;
            r_stage_data  <= '0;
        end else begin
            r_stage_valid <= bus.DataNd_i;
            if (bus.DataNd_i) begin
                r_stage_data <= w_sat;
            end
        end
    end

    assign w_full  = (r_level == LevelFull);
    assign w_valid = (r_level != '0);
    assign w_rd    = w_valid && bus.DataReady_i;
    assign w_wr    = r_stage_valid && (!w_full || w_rd);
    assign w_drop  = r_stage_valid && w_full && !w_rd;

    always_ff @(posedge Clk_i) begin
        if (w_wr && !Rst_i) begin
            r_mem[r_wr_ptr] <= r_stage_data;
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AddrWidth'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AddrWidth'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + (AddrWidth+1)'(1);
                2'b01:   r_level <= r_level - (AddrWidth+1)'(1);
                default: r_level <= r_level;
            endcase
            // A drop in the clearing cycle must stay visible, so set beats clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.OverflowClr_i) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.Data_o      = w_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.DataValid_o = w_valid;
    assign bus.Level_o     = r_level;
    assign bus.Overflow_o  = r_overflow;
endmodule

// File: tb/tb_decimator_output_fifo.sv
// tb/tb_decimator_output_fifo.sv - scoreboard bench for gain, latency, overflow, full read/write and wrap
module tb_decimator_output_fifo;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [17:0] q0[$];
    logic [17:0] q2[$];
    logic [17:0] exp_v;
    logic [17:0] last_v;

    decimator_output_fifo_if #(.DataWidth(18), .AddrWidth(4)) bus0 ();
    decimator_output_fifo_if #(.DataWidth(18), .AddrWidth(4)) bus2 ();

    decimator_output_fifo #(.DataWidth(18), .Depth(16), .AddrWidth(4), .GainShift(0))
        dut0 (.Clk_i(clk), .Rst_i(rst), .bus(bus0));
    decimator_output_fifo #(.DataWidth(18), .Depth(16), .AddrWidth(4), .GainShift(2))
        dut2 (.Clk_i(clk), .Rst_i(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus0.DataNd_i = 1'b1; bus0.Data_i = 18'h00055;
        bus2.DataNd_i = 1'b1; bus2.Data_i = 18'h00055;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if ({bus0.Data_o, bus0.DataValid_o, bus0.Level_o, bus0.Overflow_o} !== '0 ||
                {bus2.Data_o, bus2.DataValid_o, bus2.Level_o, bus2.Overflow_o} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d got data=%h valid=%b level=%0d ovf=%b want all 0",
                         i, bus0.Data_o, bus0.DataValid_o, bus0.Level_o, bus0.Overflow_o);
            end
        end
        rst = 1'b0;
        bus2.DataNd_i = 1'b0;
        bus0.Data_i = 18'h00077; q0.push_back(18'h00077);
        cyc();
        bus0.DataNd_i = 1'b0;
        checks++;
        if (bus0.DataValid_o !== 1'b0) begin
            errors++; $display("FAIL reset_release_edge1 got valid=%b want 0", bus0.DataValid_o);
        end
        cyc();
        checks++;
        if (bus0.DataValid_o !== 1'b1 || bus0.Data_o !== 18'h00077 || bus0.Level_o !== 5'd1) begin
            errors++;
            $display("FAIL reset_release_edge2 got valid=%b data=%h level=%0d want 1 00077 1",
                     bus0.DataValid_o, bus0.Data_o, bus0.Level_o);
        end
        bus0.DataReady_i = 1'b1;
        if (bus0.DataValid_o) begin
            checks++;
            exp_v = q0.pop_front();
            if (bus0.Data_o !== exp_v) begin
                errors++; $display("FAIL reset_drain got %h want %h", bus0.Data_o, exp_v);
            end
        end
        cyc();
        bus0.DataReady_i = 1'b0;
        checks++;
        if (bus0.Level_o !== 5'd0) begin
            errors++; $display("FAIL reset_drain_level got %0d want 0", bus0.Level_o);
        end
    endtask

    task automatic test_latency();
        bus0.DataReady_i = 1'b1;
        bus0.DataNd_i = 1'b1; bus0.Data_i = 18'h00123; q0.push_back(18'h00123);
        cyc();
        bus0.DataNd_i = 1'b0;
        checks++;
        if (bus0.DataValid_o !== 1'b0 || bus0.Level_o !== 5'd0) begin
            errors++; $display("FAIL latency_edge_n got valid=%b level=%0d want 0 0", bus0.DataValid_o, bus0.Level_o);
        end
        cyc();
        checks++;
        if (bus0.DataValid_o !== 1'b1 || bus0.Level_o !== 5'd1) begin
            errors++; $display("FAIL latency_edge_n1 got valid=%b level=%0d want 1 1", bus0.DataValid_o, bus0.Level_o);
        end
        if (bus0.DataValid_o && bus0.DataReady_i) begin
            checks++;
            exp_v = q0.pop_front();
            if (bus0.Data_o !== exp_v) begin
                errors++; $display("FAIL latency_data got %h want %h", bus0.Data_o, exp_v);
            end
        end
        cyc();
        checks++;
        if (bus0.DataValid_o !== 1'b0 || bus0.Level_o !== 5'd0 || bus0.Data_o !== 18'h0) begin
            errors++;
            $display("FAIL latency_edge_n2 got valid=%b level=%0d data=%h want 0 0 0",
                     bus0.DataValid_o, bus0.Level_o, bus0.Data_o);
        end
        bus0.DataReady_i = 1'b0;
    endtask

    task automatic test_saturation();
        logic [17:0] vin [5];
        logic [17:0] vout [5];
        vin  = '{18'h00100, 18'h0F000, 18'h3F000, 18'h30000, 18'h20000};
        vout = '{18'h00400, 18'h1FFFF, 18'h3C000, 18'h20000, 18'h20000};
        bus2.DataReady_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i < 5) begin
                bus2.DataNd_i = 1'b1; bus2.Data_i = vin[i]; q2.push_back(vout[i]);
            end else begin
                bus2.DataNd_i = 1'b0;
            end
            if (bus2.DataValid_o && bus2.DataReady_i) begin
                checks++;
                if (q2.size() == 0) begin
                    errors++; $display("FAIL sat_unexpected got %h want nothing", bus2.Data_o);
                end else begin
                    exp_v = q2.pop_front();
                    if (bus2.Data_o !== exp_v) begin
                        errors++; $display("FAIL sat_value got %h want %h", bus2.Data_o, exp_v);
                    end
                end
            end
            cyc();
        end
        checks++;
        if (q2.size() != 0 || bus2.Level_o !== 5'd0) begin
            errors++; $display("FAIL sat_drained got pending=%0d level=%0d want 0 0", q2.size(), bus2.Level_o);
        end
        bus2.DataReady_i = 1'b0;
    endtask

    task automatic test_overflow();
        bus0.DataReady_i = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            bus0.DataNd_i = 1'b1; bus0.Data_i = 18'(k); q0.push_back(18'(k));
            cyc();
            if (k >= 2) begin
                checks++;
                if (bus0.DataValid_o !== 1'b1 || bus0.Data_o !== 18'd1) begin
                    errors++; $display("FAIL ovf_head_hold k=%0d got %h want 00001", k, bus0.Data_o);
                end
            end
        end
        bus0.DataNd_i = 1'b0;
        cyc();
        checks++;
        if (bus0.Level_o !== 5'd16 || bus0.Data_o !== 18'd1 || bus0.Overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full got level=%0d data=%h ovf=%b want 16 00001 0",
                     bus0.Level_o, bus0.Data_o, bus0.Overflow_o);
        end
        bus0.DataNd_i = 1'b1; bus0.Data_i = 18'd17;
        cyc();
        bus0.DataNd_i = 1'b0;
        cyc();
        checks++;
        if (bus0.Level_o !== 5'd16 || bus0.Overflow_o !== 1'b1) begin
            errors++; $display("FAIL ovf_drop got level=%0d ovf=%b want 16 1", bus0.Level_o, bus0.Overflow_o);
        end
        bus0.DataReady_i = 1'b1;
        for (int i = 0; i < 24 && bus0.DataValid_o; i++) begin
            checks++;
            if (q0.size() == 0) begin
                errors++; $display("FAIL ovf_unexpected got %h want nothing", bus0.Data_o);
            end else begin
                exp_v = q0.pop_front();
                if (bus0.Data_o !== exp_v) begin
                    errors++; $display("FAIL ovf_order got %h want %h", bus0.Data_o, exp_v);
                end
            end
            cyc();
        end
        bus0.DataReady_i = 1'b0;
        checks++;
        if (bus0.Level_o !== 5'd0 || q0.size() != 0) begin
            errors++; $display("FAIL ovf_drained got level=%0d pending=%0d want 0 0", bus0.Level_o, q0.size());
        end
        bus0.OverflowClr_i = 1'b1;
        cyc();
        bus0.OverflowClr_i = 1'b0;
        checks++;
        if (bus0.Overflow_o !== 1'b0) begin
            errors++; $display("FAIL ovf_clear got %b want 0", bus0.Overflow_o);
        end
    endtask

    task automatic test_full_rw();
        for (int k = 0; k < 16; k++) begin
            bus0.DataNd_i = 1'b1; bus0.Data_i = 18'h00100 + 18'(k); q0.push_back(18'h00100 + 18'(k));
            cyc();
        end
        bus0.DataNd_i = 1'b1; bus0.Data_i = 18'h00AAA; q0.push_back(18'h00AAA);
        cyc();
        bus0.DataNd_i = 1'b0;
        checks++;
        if (bus0.Level_o !== 5'd16) begin
            errors++; $display("FAIL full_rw_prefill got level=%0d want 16", bus0.Level_o);
        end
        bus0.DataReady_i = 1'b1;
        checks++;
        exp_v = q0.pop_front();
        if (bus0.Data_o !== exp_v) begin
            errors++; $display("FAIL full_rw_head got %h want %h", bus0.Data_o, exp_v);
        end
        cyc();
        bus0.DataReady_i = 1'b0;
        checks++;
        if (bus0.Level_o !== 5'd16 || bus0.Overflow_o !== 1'b0) begin
            errors++; $display("FAIL full_rw_accept got level=%0d ovf=%b want 16 0", bus0.Level_o, bus0.Overflow_o);
        end
        bus0.DataNd_i = 1'b1; bus0.Data_i = 18'h00BBB;
        cyc();
        bus0.DataNd_i = 1'b0;
        bus0.OverflowClr_i = 1'b1;
        cyc();
        bus0.OverflowClr_i = 1'b0;
        checks++;
        if (bus0.Overflow_o !== 1'b1 || bus0.Level_o !== 5'd16) begin
            errors++; $display("FAIL full_rw_set_wins got ovf=%b level=%0d want 1 16", bus0.Overflow_o, bus0.Level_o);
        end
        last_v = '0;
        bus0.DataReady_i = 1'b1;
        for (int i = 0; i < 24 && bus0.DataValid_o; i++) begin
            checks++;
            if (q0.size() == 0) begin
                errors++; $display("FAIL full_rw_unexpected got %h want nothing", bus0.Data_o);
            end else begin
                exp_v = q0.pop_front();
                if (bus0.Data_o !== exp_v) begin
                    errors++; $display("FAIL full_rw_order got %h want %h", bus0.Data_o, exp_v);
                end
            end
            last_v = bus0.Data_o;
            cyc();
        end
        bus0.DataReady_i = 1'b0;
        checks++;
        if (last_v !== 18'h00AAA || q0.size() != 0 || bus0.Level_o !== 5'd0) begin
            errors++;
            $display("FAIL full_rw_last got last=%h pending=%0d level=%0d want 00AAA 0 0",
                     last_v, q0.size(), bus0.Level_o);
        end
        bus0.OverflowClr_i = 1'b1;
        cyc();
        bus0.OverflowClr_i = 1'b0;
    endtask

    task automatic test_reset_wrap();
        int sent;
        int got;
        for (int k = 0; k < 8; k++) begin
            bus0.DataNd_i = 1'b1; bus0.Data_i = 18'h00200 + 18'(k);
            cyc();
        end
        bus0.DataNd_i = 1'b0;
        cyc();
        checks++;
        if (bus0.Level_o !== 5'd8) begin
            errors++; $display("FAIL wrap_prefill got level=%0d want 8", bus0.Level_o);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (bus0.Level_o !== 5'd0 || bus0.DataValid_o !== 1'b0) begin
            errors++; $display("FAIL wrap_reset got level=%0d valid=%b want 0 0", bus0.Level_o, bus0.DataValid_o);
        end
        sent = 0;
        got  = 0;
        for (int c = 0; c < 40 * 8 + 60; c++) begin
            bus0.DataReady_i = ((c / 3) % 2) == 1;
            if ((c % 8) == 0 && sent < 40) begin
                bus0.DataNd_i = 1'b1;
                bus0.Data_i = 18'($urandom);
                q0.push_back(bus0.Data_i);
                sent++;
            end else begin
                bus0.DataNd_i = 1'b0;
            end
            if (bus0.DataValid_o && bus0.DataReady_i) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++; $display("FAIL wrap_unexpected got %h want nothing", bus0.Data_o);
                end else begin
                    exp_v = q0.pop_front();
                    got++;
                    if (bus0.Data_o !== exp_v) begin
                        errors++; $display("FAIL wrap_order sample %0d got %h want %h", got, bus0.Data_o, exp_v);
                    end
                end
            end
            cyc();
        end
        bus0.DataNd_i = 1'b0;
        bus0.DataReady_i = 1'b0;
        checks++;
        if (got != 40 || q0.size() != 0 || bus0.Overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_complete got count=%0d pending=%0d ovf=%b want 40 0 0",
                     got, q0.size(), bus0.Overflow_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus0.Data_i = '0; bus0.DataNd_i = 1'b0; bus0.DataReady_i = 1'b0; bus0.OverflowClr_i = 1'b0;
        bus2.Data_i = '0; bus2.DataNd_i = 1'b0; bus2.DataReady_i = 1'b0; bus2.OverflowClr_i = 1'b0;
        cyc();
        test_reset();
        test_latency();
        test_saturation();
        test_overflow();
        test_full_rw();
        test_reset_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
